// File: rtl/menu_dwell_select.sv
// Menu dwell picker: hit-tests the per-frame pointer against a COLS x ROWS cell grid
// and fires a one-cycle selection after a debounced dwell. Option: MENU_DWELL_REPEAT_EN.
module menu_dwell_select #(
    parameter int POS_W          = 13,
    parameter int X_LAST         = 799,
    parameter int Y_LAST         = 599,
    parameter int MENU_X0        = 721,
    parameter int MENU_Y0        = 171,
    parameter int CELL_W         = 39,
    parameter int CELL_H         = 38,
    parameter int COLS           = 2,
    parameter int ROWS           = 8,
    parameter int IDX_W          = 5,
    parameter int DWELL_FRAMES   = 6,
    parameter int MISS_MAX       = 5,
    parameter int TIMEOUT_FRAMES = 20,
    parameter int REPEAT_FRAMES  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] i_X_pos,
    input  logic [POS_W-1:0] i_Y_pos,
    input  logic             i_detect,
    input  logic [POS_W-1:0] i_ptr_X,
    input  logic [POS_W-1:0] i_ptr_Y,
    output logic             o_hover_valid,
    output logic [IDX_W-1:0] o_hover_idx,
    output logic [4:0]       o_progress,
    output logic             o_sel_valid,
    output logic [IDX_W-1:0] o_sel_idx,
    output logic             o_busy
);
    localparam int EXT_W = POS_W + 4;
    localparam logic [15:0] DWELL_C   = 16'(DWELL_FRAMES);
    localparam logic [15:0] MISS_C    = 16'(MISS_MAX);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_FRAMES);
`ifdef MENU_DWELL_REPEAT_EN
    localparam logic [15:0] REPEAT_C  = 16'(REPEAT_FRAMES);
`endif

    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_COOL} state_t;

    state_t             state_q, state_d;
    logic               fr_valid_q, fr_valid_d;
    logic [POS_W-1:0]   fr_x_q, fr_x_d, fr_y_q, fr_y_d;
    logic [IDX_W-1:0]   cand_q, cand_d;
    logic [15:0]        cnt_q, cnt_d, miss_q, miss_d, frames_q, frames_d, rep_q, rep_d;
    logic               hover_valid_q, hover_valid_d, sel_valid_q, sel_valid_d;
    logic [IDX_W-1:0]   hover_idx_q, hover_idx_d, sel_idx_q, sel_idx_d;
    logic [4:0]         progress_q, progress_d;

    logic               end_frame, ptr_valid, hit;
    logic [EXT_W-1:0]   ptr_x_ext, ptr_y_ext;
    logic [COLS-1:0]    col_hit;
    logic [ROWS-1:0]    row_hit;
    logic [IDX_W-1:0]   col_idx, row_idx, hit_idx;

    assign end_frame = (i_X_pos == POS_W'(X_LAST)) && (i_Y_pos == POS_W'(Y_LAST));

    // A detect on the end_frame cycle itself overrides the captured pointer.
    assign ptr_valid = i_detect | fr_valid_q;
    assign ptr_x_ext = {4'b0, (i_detect ? i_ptr_X : fr_x_q)};
    assign ptr_y_ext = {4'b0, (i_detect ? i_ptr_Y : fr_y_q)};

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            localparam logic [EXT_W-1:0] LO = EXT_W'(MENU_X0 + gi * CELL_W);
            localparam logic [EXT_W-1:0] HI = EXT_W'(MENU_X0 + (gi + 1) * CELL_W);
            assign col_hit[gi] = (ptr_x_ext >= LO) && (ptr_x_ext < HI);
        end
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            localparam logic [EXT_W-1:0] LO = EXT_W'(MENU_Y0 + gi * CELL_H);
            localparam logic [EXT_W-1:0] HI = EXT_W'(MENU_Y0 + (gi + 1) * CELL_H);
            assign row_hit[gi] = (ptr_y_ext >= LO) && (ptr_y_ext < HI);
        end
    endgenerate

    always_comb begin
        col_idx = '0;
        row_idx = '0;
        for (int i = 0; i < COLS; i++) if (col_hit[i]) col_idx = IDX_W'(i);
        for (int i = 0; i < ROWS; i++) if (row_hit[i]) row_idx = IDX_W'(i);
    end

    assign hit     = ptr_valid && (|col_hit) && (|row_hit);
    assign hit_idx = IDX_W'(row_idx * IDX_W'(COLS)) + col_idx;

    always_comb begin
        fr_valid_d    = fr_valid_q;
        fr_x_d        = fr_x_q;
        fr_y_d        = fr_y_q;
        state_d       = state_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        miss_d        = miss_q;
        frames_d      = frames_q;
        rep_d         = rep_q;
        hover_valid_d = hover_valid_q;
        hover_idx_d   = hover_idx_q;
        sel_valid_d   = 1'b0;
        sel_idx_d     = sel_idx_q;

        if (end_frame) begin
            fr_valid_d = 1'b0;
        end else if (i_detect) begin
            fr_valid_d = 1'b1;
            fr_x_d     = i_ptr_X;
            fr_y_d     = i_ptr_Y;
        end

        if (end_frame) begin
            hover_valid_d = hit;
            if (hit) hover_idx_d = hit_idx;
            unique case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        cand_d   = hit_idx;
                        cnt_d    = 16'd1;
                        miss_d   = '0;
                        frames_d = 16'd1;
                        rep_d    = '0;
                        if (DWELL_C <= 16'd1) begin
                            sel_valid_d = 1'b1;
                            sel_idx_d   = hit_idx;
                            state_d     = S_COOL;
                        end else begin
                            state_d = S_DWELL;
                        end
                    end
                end
                S_DWELL: begin
                    frames_d = frames_q + 16'd1;
                    if (hit && hit_idx == cand_q) begin
                        cnt_d  = cnt_q + 16'd1;
                        miss_d = '0;
                        if (cnt_q + 16'd1 >= DWELL_C) begin
                            sel_valid_d = 1'b1;
                            sel_idx_d   = cand_q;
                            rep_d       = '0;
                            state_d     = S_COOL;
                        end
                    end else if (hit) begin
                        cand_d   = hit_idx;
                        cnt_d    = 16'd1;
                        miss_d   = '0;
                        frames_d = 16'd1;
                    end else begin
                        miss_d = miss_q + 16'd1;
                        if (miss_q + 16'd1 > MISS_C) state_d = S_IDLE;
                    end
                    // Checked after the rules so a completing dwell beats the timeout.
                    if (state_d == S_DWELL && frames_d >= TIMEOUT_C) state_d = S_IDLE;
                end
                S_COOL: begin
                    if (hit && hit_idx == cand_q) begin
`ifdef MENU_DWELL_REPEAT_EN
                        if (rep_q + 16'd1 >= REPEAT_C) begin
                            rep_d       = '0;
                            sel_valid_d = 1'b1;
                            sel_idx_d   = cand_q;
                        end else begin
                            rep_d = rep_q + 16'd1;
                        end
`else
                        rep_d = rep_q;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        progress_d = '0;
        if (state_d == S_DWELL) progress_d = (cnt_d > 16'd31) ? 5'd31 : cnt_d[4:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            fr_valid_q    <= 1'b0;
            fr_x_q        <= '0;
            fr_y_q        <= '0;
            cand_q        <= '0;
            cnt_q         <= '0;
            miss_q        <= '0;
            frames_q      <= '0;
            rep_q         <= '0;
            hover_valid_q <= 1'b0;
            hover_idx_q   <= '0;
            sel_valid_q   <= 1'b0;
            sel_idx_q     <= '0;
            progress_q    <= '0;
        end else begin
            state_q       <= state_d;
            fr_valid_q    <= fr_valid_d;
            fr_x_q        <= fr_x_d;
            fr_y_q        <= fr_y_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            miss_q        <= miss_d;
            frames_q      <= frames_d;
            rep_q         <= rep_d;
            hover_valid_q <= hover_valid_d;
            hover_idx_q   <= hover_idx_d;
            sel_valid_q   <= sel_valid_d;
            sel_idx_q     <= sel_idx_d;
            progress_q    <= progress_d;
        end
    end

    assign o_hover_valid = hover_valid_q;
    assign o_hover_idx   = hover_idx_q;
    assign o_progress    = progress_q;
    assign o_sel_valid   = sel_valid_q;
    assign o_sel_idx     = sel_idx_q;
    assign o_busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_menu_dwell_select.sv
// Directed bench for menu_dwell_select: short synthetic frames, expected results
// queued per frame and checked one cycle after each end_frame.
module tb_menu_dwell_select;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] i_X_pos = '0, i_Y_pos = '0, i_ptr_X = '0, i_ptr_Y = '0;
    logic        i_detect = 1'b0;
    logic        o_hover_valid, o_sel_valid, o_busy;
    logic [4:0]  o_hover_idx, o_sel_idx, o_progress;

    always #5 clk = ~clk;

    menu_dwell_select dut (
        .clk(clk), .rst(rst), .i_X_pos(i_X_pos), .i_Y_pos(i_Y_pos),
        .i_detect(i_detect), .i_ptr_X(i_ptr_X), .i_ptr_Y(i_ptr_Y),
        .o_hover_valid(o_hover_valid), .o_hover_idx(o_hover_idx),
        .o_progress(o_progress), .o_sel_valid(o_sel_valid),
        .o_sel_idx(o_sel_idx), .o_busy(o_busy)
    );

    typedef struct {
        logic       hv;
        logic [4:0] hi;
        logic       sv;
        logic [4:0] prog;
        logic       busy;
    } exp_t;

    exp_t       sb_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [4:0] exp_sel_idx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame: three ordinary cycles (detect on the middle one unless on_end) then end_frame.
    task automatic frame(input logic det, input logic on_end, input logic [12:0] px,
                         input logic [12:0] py, input logic hv, input logic [4:0] hi,
                         input logic sv, input logic [4:0] prog, input logic busy);
        logic stray;
        exp_t e;
        stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_X_pos  = 13'(k);
            i_Y_pos  = '0;
            i_detect = det && !on_end && (k == 1);
            i_ptr_X  = px;
            i_ptr_Y  = py;
            @(posedge clk);
            #1;
            stray = stray | o_sel_valid;
        end
        i_X_pos  = 13'd799;
        i_Y_pos  = 13'd599;
        i_detect = det && on_end;
        e = '{hv, hi, sv, prog, busy};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        i_detect = 1'b0;
        e = sb_q.pop_front();
        chk("stray_pulse", 32'(stray), 32'd0);
        chk("hover_valid", 32'(o_hover_valid), 32'(e.hv));
        if (e.hv) chk("hover_idx", 32'(o_hover_idx), 32'(e.hi));
        chk("sel_valid", 32'(o_sel_valid), 32'(e.sv));
        chk("sel_idx", 32'(o_sel_idx), 32'(exp_sel_idx));
        chk("progress", 32'(o_progress), 32'(e.prog));
        chk("busy", 32'(o_busy), 32'(e.busy));
        $display("frame ptr=(%0d,%0d) det=%0b hv=%0b hi=%0d sel=%0b/%0d prog=%0d busy=%0b",
                 px, py, det, o_hover_valid, o_hover_idx, o_sel_valid, o_sel_idx,
                 o_progress, o_busy);
    endtask

    task automatic hit(input logic [12:0] px, input logic [12:0] py, input logic [4:0] idx,
                       input logic sv, input logic [4:0] prog, input logic busy);
        frame(1'b1, 1'b0, px, py, 1'b1, idx, sv, prog, busy);
    endtask

    task automatic miss(input logic [4:0] prog, input logic busy);
        frame(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, prog, busy);
    endtask

    initial begin
        logic rep_sv;
        // Reset held with the pointer parked inside the grid.
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) frame(1'b1, 1'b0, 13'd770, 13'd260, 1'b0, '0, 1'b0, '0, 1'b0);
        rst = 1'b1;

        // Plain dwell on idx 5.
        for (int n = 1; n <= 5; n++) hit(13'd770, 13'd260, 5'd5, 1'b0, 5'(n), 1'b1);
        exp_sel_idx = 5'd5;
        hit(13'd770, 13'd260, 5'd5, 1'b1, 5'd0, 1'b1);
        miss(5'd0, 1'b0);

        // Candidate switch from idx 0 to idx 2 restarts the count.
        for (int n = 1; n <= 3; n++) hit(13'd730, 13'd180, 5'd0, 1'b0, 5'(n), 1'b1);
        for (int n = 1; n <= 5; n++) hit(13'd730, 13'd220, 5'd2, 1'b0, 5'(n), 1'b1);
        exp_sel_idx = 5'd2;
        hit(13'd730, 13'd220, 5'd2, 1'b1, 5'd0, 1'b1);
        hit(13'd730, 13'd220, 5'd2, 1'b0, 5'd0, 1'b1);
        hit(13'd730, 13'd220, 5'd2, 1'b0, 5'd0, 1'b1);
        miss(5'd0, 1'b0);

        // Six consecutive misses abandon the dwell.
        hit(13'd730, 13'd180, 5'd0, 1'b0, 5'd1, 1'b1);
        hit(13'd730, 13'd180, 5'd0, 1'b0, 5'd2, 1'b1);
        for (int n = 0; n < 5; n++) miss(5'd2, 1'b1);
        miss(5'd0, 1'b0);

        // Five misses are tolerated; the dwell completes on the sixth hit.
        hit(13'd730, 13'd180, 5'd0, 1'b0, 5'd1, 1'b1);
        hit(13'd730, 13'd180, 5'd0, 1'b0, 5'd2, 1'b1);
        for (int n = 0; n < 5; n++) miss(5'd2, 1'b1);
        for (int n = 3; n <= 5; n++) hit(13'd730, 13'd180, 5'd0, 1'b0, 5'(n), 1'b1);
        exp_sel_idx = 5'd0;
        hit(13'd730, 13'd180, 5'd0, 1'b1, 5'd0, 1'b1);
        miss(5'd0, 1'b0);

        // Sparse hits on idx 3 run into the 20-frame timeout.
        for (int f = 1; f <= 19; f++) begin
            if ((f - 1) % 4 == 0) hit(13'd770, 13'd220, 5'd3, 1'b0, 5'((f - 1) / 4 + 1), 1'b1);
            else miss(5'((f - 1) / 4 + 1), 1'b1);
        end
        miss(5'd0, 1'b0);

        // Select idx 3, then rest on it for 40 frames.
        for (int n = 1; n <= 5; n++) hit(13'd770, 13'd220, 5'd3, 1'b0, 5'(n), 1'b1);
        exp_sel_idx = 5'd3;
        hit(13'd770, 13'd220, 5'd3, 1'b1, 5'd0, 1'b1);
        for (int k = 1; k <= 40; k++) begin
`ifdef MENU_DWELL_REPEAT_EN
            rep_sv = (k % 15 == 0);
`else
            rep_sv = 1'b0;
`endif
            hit(13'd770, 13'd220, 5'd3, rep_sv, 5'd0, 1'b1);
        end
        miss(5'd0, 1'b0);

        // Detect only on the end_frame cycle; right-edge boundary; reset mid-dwell.
        frame(1'b1, 1'b1, 13'd790, 13'd470, 1'b1, 5'd15, 1'b0, 5'd1, 1'b1);
        frame(1'b1, 1'b1, 13'd800, 13'd470, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
        frame(1'b1, 1'b1, 13'd790, 13'd470, 1'b1, 5'd15, 1'b0, 5'd2, 1'b1);
        rst = 1'b0;
        exp_sel_idx = 5'd0;
        frame(1'b1, 1'b0, 13'd790, 13'd470, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        miss(5'd0, 1'b0);
        hit(13'd790, 13'd470, 5'd15, 1'b0, 5'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
